// File: rtl/fp_add_sequencer_pkg.sv
// fp_add_sequencer_pkg: float type, sequencer states and operand classification
package fp_add_sequencer_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float;
  localparam float QNAN = 32'h7FC00000;
  typedef enum logic [2:0] {IDLE, DISPATCH, ARM, WAIT, OUT} seq_state_t;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;
  // Denormals fold into ZERO: the core only handles normal, finite operands.
  function automatic fp_class_t fp_classify(float f);
    return f.exp == 8'd0 ? ZERO : f.exp != 8'hFF ? NORMAL : f.frac == '0 ? INF : NAN;
  endfunction
endpackage

// File: rtl/fp_operand_fifo.sv
// fp_operand_fifo: count-based circular buffer of operand pairs
module fp_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  // storage needs no reset: an entry is only read after it has been counted in
  always_ff @(posedge Clock)
    if (push_i) mem_q[wr_q] <= data_i;
  // pointers wrap on their own at the power-of-two depth; push+pop leaves the count unchanged
  always_ff @(posedge Clock)
    if (Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign data_o  = mem_q[rd_q];
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: queues operand pairs, resolves IEEE special cases locally and runs normal pairs through the adder core
module fp_add_sequencer
  import fp_add_sequencer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic Clock,
  input  logic Reset,
  input  float InA,
  input  float InB,
  input  logic InValid,
  output logic InReady,
  output float FpaA,
  output float FpaB,
  output logic FpaGo,
  input  logic FpaReady,
  input  float FpaResult,
  output float OutResult,
  output logic OutValid,
  input  logic OutReady,
  output logic OutZero,
  output logic OutInf,
  output logic OutNan,
  output logic Busy,
  output logic Timeout
);
  seq_state_t       state_q;
  float             op_a_q, op_b_q, res_q, head_a, head_b, core_fix;
  logic             go_q, valid_q, timeout_q, empty, full, pop;
  logic [CNT_W-1:0] wd_q;
  function automatic logic is_special(float a, float b);
    return fp_classify(a) != NORMAL || fp_classify(b) != NORMAL;
  endfunction
  // Priority: NaN, opposite infinities, infinity, two zeros, one zero (other operand passes through).
  function automatic float resolve(float a, float b);
    fp_class_t ca = fp_classify(a);
    fp_class_t cb = fp_classify(b);
    return (ca == NAN || cb == NAN || (ca == INF && cb == INF && a.sign != b.sign)) ? QNAN :
           ca == INF ? a : cb == INF ? b :
           (ca == ZERO && cb == ZERO) ? float'({a.sign & b.sign, 31'd0}) :
           ca == ZERO ? b : a;
  endfunction
  assign pop     = state_q == IDLE && !empty;
  assign InReady = !full;
  fp_operand_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .push_i (InValid && !full),
    .pop_i  (pop),
    .data_i ({InA, InB}),
    .data_o ({head_a, head_b}),
    .empty_o(empty),
    .full_o (full)
  );
  // core overflow reports exp==255 with junk fraction; squash it to a signed infinity
  assign core_fix = {FpaResult.sign, FpaResult.exp, FpaResult.exp == 8'hFF ? 23'd0 : FpaResult.frac};
  // sequencer: Go is raised on the pop edge so it coincides with the operand registers in DISPATCH
  always_ff @(posedge Clock)
    if (Reset) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      go_q      <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      go_q <= 1'b0;
      case (state_q)
        IDLE: if (!empty) begin
          op_a_q  <= head_a;
          op_b_q  <= head_b;
          go_q    <= !is_special(head_a, head_b);
          state_q <= DISPATCH;
        end
        DISPATCH: if (is_special(op_a_q, op_b_q)) begin
          res_q   <= resolve(op_a_q, op_b_q);
          valid_q <= 1'b1;
          state_q <= OUT;
        end else state_q <= ARM;
        ARM: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: if (FpaReady) begin
          res_q   <= core_fix;
          valid_q <= 1'b1;
          state_q <= OUT;
        end else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          res_q     <= QNAN;
          timeout_q <= 1'b1;
          valid_q   <= 1'b1;
          state_q   <= OUT;
        end else wd_q <= wd_q + CNT_W'(1);
        OUT: if (OutReady) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign FpaA      = op_a_q;
  assign FpaB      = op_b_q;
  assign FpaGo     = go_q;
  assign OutResult = res_q;
  assign OutValid  = valid_q;
  assign Timeout   = timeout_q;
  assign Busy      = state_q != IDLE || !empty;
  assign OutZero   = valid_q && res_q.exp == 8'd0;
  assign OutInf    = valid_q && res_q.exp == 8'hFF && res_q.frac == '0;
  assign OutNan    = valid_q && res_q.exp == 8'hFF && res_q.frac != '0;
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: random and directed operand pairs scored against an IEEE special-case model and a core model
module tb_fp_add_sequencer;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  logic Clock = 0, Reset = 1;
  logic [31:0] InA = 0, InB = 0, FpaA, FpaB, FpaResult = 0, OutResult;
  logic InValid = 0, InReady, FpaGo, FpaReady = 1, OutValid, OutReady = 0;
  logic OutZero, OutInf, OutNan, Busy, Timeout;
  int errors = 0, checks = 0, go_cnt = 0, n_out = 0, lat = 4, left = 0;
  bit hang = 0, lat_rand = 0, done = 0, core_busy = 0;
  logic [31:0] last_out = 0, cap_a = 0, cap_b = 0;
  logic [2:0] last_flags = 0;
  typedef struct { logic [31:0] a, b, val; bit normal; } exp_t;
  exp_t exp_q[$];
  logic [31:0] core_q[$];

  fp_add_sequencer dut (
    .Clock(Clock), .Reset(Reset), .InA(InA), .InB(InB), .InValid(InValid), .InReady(InReady),
    .FpaA(FpaA), .FpaB(FpaB), .FpaGo(FpaGo), .FpaReady(FpaReady), .FpaResult(FpaResult),
    .OutResult(OutResult), .OutValid(OutValid), .OutReady(OutReady),
    .OutZero(OutZero), .OutInf(OutInf), .OutNan(OutNan), .Busy(Busy), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic bit is_nan(logic [31:0] x);  return x[30:23] == 8'hFF && x[22:0] != 0; endfunction
  function automatic bit is_inf(logic [31:0] x);  return x[30:23] == 8'hFF && x[22:0] == 0; endfunction
  function automatic bit is_zero(logic [31:0] x); return x[30:23] == 8'h00; endfunction
  function automatic logic [2:0] flags_of(logic [31:0] x);
    return {is_zero(x), is_inf(x), is_nan(x)};
  endfunction

  // {special, value}; value is only meaningful for special pairs
  function automatic logic [32:0] ref_special(logic [31:0] a, logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return {1'b1, QNAN};
    if (is_inf(a) && is_inf(b) && a[31] != b[31]) return {1'b1, QNAN};
    if (is_inf(a)) return {1'b1, a};
    if (is_inf(b)) return {1'b1, b};
    if (is_zero(a) && is_zero(b)) return {1'b1, a[31] & b[31], 31'd0};
    if (is_zero(a)) return {1'b1, b};
    if (is_zero(b)) return {1'b1, a};
    return 33'd0;
  endfunction

  function automatic logic [31:0] fix(logic [31:0] r);
    return is_nan(r) ? {r[31], 8'hFF, 23'd0} : r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0: begin r[30:23] = 8'h00; if ($urandom_range(0, 1) == 1) r[22:0] = 0; end
      1: r[30:0] = {8'hFF, 23'd0};
      2: begin r[30:23] = 8'hFF; if (r[22:0] == 0) r[0] = 1'b1; end
      default: if (r[30:23] == 8'h00 || r[30:23] == 8'hFF) r[30:23] = 8'h80;
    endcase
    return r;
  endfunction

  // input scoreboard: record every accepted pair with its expected class
  always @(negedge Clock) if (!Reset && InValid && InReady) begin
    logic [32:0] s;
    s = ref_special(InA, InB);
    exp_q.push_back('{a: InA, b: InB, val: s[31:0], normal: !s[32]});
  end

  // output scoreboard: results must come back in push order
  always @(negedge Clock) if (!Reset && OutValid && OutReady) begin
    logic [31:0] want;
    if (exp_q.size() == 0) check("spurious_out", 0, 1);
    else begin
      want = exp_q[0].val;
      if (exp_q[0].normal) want = hang ? QNAN : (core_q.size() != 0 ? fix(core_q.pop_front()) : 32'hx);
      void'(exp_q.pop_front());
      check("result", OutResult, want);
      check("flags", {OutZero, OutInf, OutNan}, flags_of(want));
    end
    n_out++;
    last_out   = OutResult;
    last_flags = {OutZero, OutInf, OutNan};
  end

  // core model: Ready drops on Go, returns a result after the programmed latency unless hung
  always @(negedge Clock) begin
    if (Reset) begin
      FpaReady  = 1'b1;
      core_busy = 0;
    end else begin
      if (core_busy && !hang) begin
        if (left == 0) begin
          check("hold_a", FpaA, cap_a);
          check("hold_b", FpaB, cap_b);
          FpaReady  = 1'b1;
          FpaResult = core_q[core_q.size()-1];
          core_busy = 0;
        end else left--;
      end
      if (FpaGo) begin
        logic [31:0] r;
        go_cnt++;
        if (exp_q.size() == 0) check("go_unexpected", 0, 1);
        else begin
          check("go_a", FpaA, exp_q[0].a);
          check("go_b", FpaB, exp_q[0].b);
          check("go_normal", {31'd0, exp_q[0].normal}, 1);
        end
        cap_a = FpaA;
        cap_b = FpaB;
        core_busy = 1;
        FpaReady  = 1'b0;
        left = lat_rand ? $urandom_range(2, 8) : lat;
        if ({FpaA, FpaB} == {32'h3F800000, 32'h40000000}) r = 32'h40400000;
        else if ({FpaA, FpaB} == {32'h40400000, 32'h3F800000}) r = 32'h40800000;
        else begin
          r = $urandom;
          if ($urandom_range(0, 5) == 0) r[30:23] = 8'hFF;
        end
        if (!hang) core_q.push_back(r);
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(posedge Clock); #1;
    InA = a; InB = b; InValid = 1;
    do begin @(negedge Clock); n++; end while (!InReady && n < 300);
    check("push_accept", InReady, 1);
    @(posedge Clock); #1 InValid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || Busy) && n < 600) begin @(negedge Clock); n++; end
    check("drain", n < 600, 1);
  endtask

  int g0, n0, k;

  initial begin
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_valid", OutValid, 0);
    check("rst_go", FpaGo, 0);
    check("rst_timeout", Timeout, 0);
    check("rst_busy", Busy, 0);
    check("rst_inready", InReady, 1);
    check("rst_result", OutResult, 0);
    check("rst_fpa", FpaA, 0);
    check("rst_flags", {OutZero, OutInf, OutNan}, 0);
    @(posedge Clock); #1 Reset = 0;

    OutReady = 1; lat = 10; g0 = go_cnt;
    push(32'h3F800000, 32'h40000000);
    @(negedge Clock); check("go_early", FpaGo, 0);
    @(negedge Clock); check("go_cycle", FpaGo, 1);
    drain();
    check("normal_go_count", go_cnt - g0, 1);
    check("normal_sum", last_out, 32'h40400000);
    check("normal_flags", last_flags, 0);

    g0 = go_cnt;
    push(32'h7F800000, 32'hFF800000);
    @(negedge Clock); @(negedge Clock); check("special_lat_early", OutValid, 0);
    @(negedge Clock); check("special_lat", OutValid, 1);
    check("inf_cancel", OutResult, QNAN);
    check("inf_cancel_nan", OutNan, 1);
    drain();
    push(32'h00000000, 32'hC0A00000);
    drain();
    check("zero_bypass", last_out, 32'hC0A00000);
    push(32'h80000000, 32'h80000000);
    drain();
    check("neg_zeros", last_out, 32'h80000000);
    check("neg_zeros_flags", last_flags, 3'b100);
    check("special_no_go", go_cnt - g0, 0);

    lat_rand = 1; OutReady = 0; n0 = n_out;
    repeat (5) push(rand_op(), rand_op());
    repeat (30) @(negedge Clock);
    check("bp_full", InReady, 0);
    check("bp_held", OutValid, 1);
    check("bp_none_out", n_out - n0, 0);
    fork
      push(rand_op(), rand_op());
      begin repeat (5) @(posedge Clock); #1 OutReady = 1; end
    join
    drain();
    check("bp_count", n_out - n0, 6);

    n0 = n_out;
    fork
      begin for (int i = 0; i < 40; i++) push(rand_op(), rand_op()); done = 1; end
      begin while (!done) begin @(posedge Clock); #1 OutReady = $urandom_range(0, 2) != 0; end OutReady = 1; end
    join
    drain();
    check("rand_count", n_out - n0, 40);

    check("wd_pre", Timeout, 0);
    hang = 1;
    push(32'h3F800000, 32'h3FC00000);
    repeat (60) @(negedge Clock);
    check("wd_early", Timeout, 0);
    k = 0;
    while (!Timeout && k < 30) begin @(negedge Clock); k++; end
    check("wd_set", Timeout, 1);
    drain();
    check("wd_qnan", last_out, QNAN);
    check("wd_nan_flag", last_flags, 3'b001);
    repeat (5) @(negedge Clock);
    check("wd_sticky", Timeout, 1);

    push(32'h40000000, 32'h3F800000);
    repeat (10) @(posedge Clock);
    #1 Reset = 1;
    @(posedge Clock); #1 Reset = 0;
    exp_q.delete(); core_q.delete();
    @(negedge Clock);
    check("rst2_valid", OutValid, 0);
    check("rst2_go", FpaGo, 0);
    check("rst2_timeout", Timeout, 0);
    check("rst2_busy", Busy, 0);
    check("rst2_inready", InReady, 1);
    hang = 0; lat_rand = 0; lat = 4;
    push(32'h40400000, 32'h3F800000);
    drain();
    check("post_rst_sum", last_out, 32'h40800000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
